sc_score_engine: RTL and testbench

Parametrised scoring engine for the game's score-computation path. It accepts per-fret hit and miss events from the note matcher and buffers one event per fret. A round-robin arbiter serialises the buffered events into a two-stage grade/score pipeline, which maintains the score, streak and multiplier for the AV block.

---
 rtl/sc_pkg.sv | 42 ++++
 rtl/sc_score_engine_if.sv | 34 +++
 rtl/sc_rr_arbiter.sv | 50 +++++
 rtl/sc_score_engine.sv | 268 ++++++++++++++++++++++++++
 tb/tb_sc_score_engine.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_pkg.sv
// sc_pkg: shared types and helpers for the score engine.
//   grade_e        - MISS / OK / GOOD / PERFECT encoding (matches the grade port)
//   PTS_*          - base points per grade; EARLY_PENALTY for early GOOD/OK hits
//   signed_dt()    - song_time - hit_time taken mod 2^tw, returned sign-extended
//   grade_points() - base points for a grade
// Optional feature macro used by the engine: SC_EARLY_LATE_EN.
package sc_pkg;

  typedef enum logic [1:0] {
    GR_MISS    = 2'd0,
    GR_OK      = 2'd1,
    GR_GOOD    = 2'd2,
    GR_PERFECT = 2'd3
  } grade_e;

  localparam int         PTS_W         = 7;
  localparam logic [6:0] PTS_PERFECT   = 7'd100;
  localparam logic [6:0] PTS_GOOD      = 7'd50;
  localparam logic [6:0] PTS_OK        = 7'd20;
  localparam logic [6:0] PTS_MISS      = 7'd0;
  localparam logic [6:0] EARLY_PENALTY = 7'd10;

  // The subtraction wraps at 2^tw, then bit tw-1 is treated as the sign by
  // shifting it up to bit 31 and arithmetic-shifting back down.
  function automatic logic signed [31:0] signed_dt(input logic [31:0] now_t,
                                                   input logic [31:0] sched_t,
                                                   input int          tw);
    logic [31:0] diff;
    diff = now_t - sched_t;
    return $signed(diff << (32 - tw)) >>> (32 - tw);
  endfunction

  function automatic logic [6:0] grade_points(input grade_e g);
    case (g)
      GR_PERFECT: return PTS_PERFECT;
      GR_GOOD:    return PTS_GOOD;
      GR_OK:      return PTS_OK;
      default:    return PTS_MISS;
    endcase
  endfunction

endpackage

// File: rtl/sc_score_engine_if.sv
// sc_score_engine_if: event and score bundle between the note matcher / AV
// block (master) and the scoring engine (slave).
//   pause, song_time, hit_valid, hit_time, miss    : master -> engine
//   score, streak, mult, grade_valid, grade,
//   grade_ch, early, overflow                      : engine -> master
interface sc_score_engine_if #(
  parameter int N_CH = 5,
  parameter int TW   = 16,
  parameter int SW   = 32
);
  logic                 pause;
  logic [TW-1:0]        song_time;
  logic [N_CH-1:0]      hit_valid;
  logic [N_CH*TW-1:0]   hit_time;
  logic [N_CH-1:0]      miss;
  logic [SW-1:0]        score;
  logic [15:0]          streak;
  logic [2:0]           mult;
  logic                 grade_valid;
  logic [1:0]           grade;
  logic [2:0]           grade_ch;
  logic                 early;
  logic                 overflow;

  modport master (
    output pause, song_time, hit_valid, hit_time, miss,
    input  score, streak, mult, grade_valid, grade, grade_ch, early, overflow
  );

  modport slave (
    input  pause, song_time, hit_valid, hit_time, miss,
    output score, streak, mult, grade_valid, grade, grade_ch, early, overflow
  );
endinterface

// File: rtl/sc_rr_arbiter.sv
// sc_rr_arbiter: round-robin arbiter over N request lines.
//   clk, rst  - clock, asynchronous active-high reset
//   pause     - suppresses all grants while high
//   req       - request vector (one bit per fret)
//   gnt       - one-hot grant (combinational)
//   gnt_idx   - encoded index of the grant
//   gnt_valid - a grant is issued this cycle
// The search starts at ptr_reg; after a grant the pointer moves to grant+1.
module sc_rr_arbiter #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pause,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [2:0]   gnt_idx,
  output logic         gnt_valid
);

  logic [2:0] ptr_reg;

  always_comb begin
    int idx;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = 0;
    if (!pause) begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr_reg) + k;
        if (idx >= N) idx = idx - N;
        if (!gnt_valid && req[idx]) begin
          gnt_valid = 1'b1;
          gnt[idx]  = 1'b1;
          gnt_idx   = 3'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= 3'd0;
    end else if (gnt_valid) begin
      ptr_reg <= (int'(gnt_idx) == N - 1) ? 3'd0 : gnt_idx + 3'd1;
    end
  end

endmodule

// File: rtl/sc_score_engine.sv
// sc_score_engine: per-fret hit/miss capture, round-robin serialisation and a
// two-stage grade/score pipeline.
//   clk, rst - 100 MHz clock, asynchronous active-high reset
//   bus      - sc_score_engine_if.slave: pause, song_time, hit_valid, hit_time,
//              miss in; score, streak, mult, grade_valid, grade, grade_ch,
//              early, overflow out
// Event sampled at edge k -> pending at k, S1 at k+1, S2 at k+2, outputs at k+3.
// Optional feature: define SC_EARLY_LATE_EN to store the dt sign, drive early
// and take EARLY_PENALTY off early GOOD/OK hits; otherwise early is 0.
module sc_score_engine
  import sc_pkg::*;
#(
  parameter int N_CH        = 5,
  parameter int TW          = 16,
  parameter int SW          = 32,
  parameter int WIN_PERFECT = 8,
  parameter int WIN_GOOD    = 24,
  parameter int WIN_OK      = 48,
  parameter int STREAK_STEP = 10,
  parameter int MAX_MULT    = 4
) (
  input logic              clk,
  input logic              rst,
  sc_score_engine_if.slave bus
);

  // |dt| is saturated to 2^(TW-1)-1, so TW-1 bits hold it.
  localparam int            MW      = TW - 1;
  localparam logic [MW-1:0] MAG_MAX = {MW{1'b1}};

  // ---------------- capture buffers ----------------
  logic [N_CH-1:0] pend_reg;
  logic [N_CH-1:0] kmiss_reg;
  logic [MW-1:0]   mag_reg [N_CH];
  logic [MW-1:0]   cap_mag [N_CH];
  logic [N_CH-1:0] ev;
  logic [N_CH-1:0] drop;
  logic [N_CH-1:0] gnt;
  logic [2:0]      gnt_idx;
  logic            gnt_valid;
`ifdef SC_EARLY_LATE_EN
  logic [N_CH-1:0] cap_neg;
  logic [N_CH-1:0] neg_reg;
`endif

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_cap
      logic signed [31:0] sdt;
      logic [32:0]        mag33;
      assign sdt   = signed_dt(32'(bus.song_time), 32'(bus.hit_time[gi*TW +: TW]), TW);
      // Negating the 33-bit sign extension keeps |-2^31| representable.
      assign mag33 = sdt[31] ? -{sdt[31], sdt} : {1'b0, sdt};
      assign cap_mag[gi] = (mag33 > 33'(MAG_MAX)) ? MAG_MAX : mag33[MW-1:0];
      assign ev[gi]      = bus.hit_valid[gi] | bus.miss[gi];
      // Lost events: a miss colliding with a hit, or anything landing on a
      // still-occupied buffer that is not being drained this cycle.
      assign drop[gi]    = (bus.hit_valid[gi] & bus.miss[gi]) |
                           (ev[gi] & pend_reg[gi] & ~gnt[gi]);
`ifdef SC_EARLY_LATE_EN
      assign cap_neg[gi] = sdt[31];
`endif
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_reg  <= '0;
      kmiss_reg <= '0;
      for (int i = 0; i < N_CH; i++) mag_reg[i] <= '0;
`ifdef SC_EARLY_LATE_EN
      neg_reg   <= '0;
`endif
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (ev[i] && (!pend_reg[i] || gnt[i])) begin
          // Hit wins over a same-cycle miss; a granted slot refills directly.
          pend_reg[i]  <= 1'b1;
          mag_reg[i]   <= cap_mag[i];
          kmiss_reg[i] <= ~bus.hit_valid[i];
`ifdef SC_EARLY_LATE_EN
          neg_reg[i]   <= cap_neg[i] & bus.hit_valid[i];
`endif
        end else if (gnt[i]) begin
          pend_reg[i] <= 1'b0;
        end
      end
    end
  end

  sc_rr_arbiter #(.N(N_CH)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .pause     (bus.pause),
    .req       (pend_reg),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // ---------------- S1: granted event ----------------
  logic [MW-1:0] sel_mag;
  logic          sel_miss;
  logic          s1_valid_reg;
  logic [MW-1:0] s1_mag_reg;
  logic          s1_miss_reg;
  logic [2:0]    s1_ch_reg;
`ifdef SC_EARLY_LATE_EN
  logic          sel_neg;
  logic          s1_neg_reg;
`endif

  always_comb begin
    sel_mag  = '0;
    sel_miss = 1'b0;
`ifdef SC_EARLY_LATE_EN
    sel_neg  = 1'b0;
`endif
    for (int i = 0; i < N_CH; i++) begin
      if (gnt[i]) begin
        sel_mag  = mag_reg[i];
        sel_miss = kmiss_reg[i];
`ifdef SC_EARLY_LATE_EN
        sel_neg  = neg_reg[i];
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_mag_reg   <= '0;
      s1_miss_reg  <= 1'b0;
      s1_ch_reg    <= 3'd0;
`ifdef SC_EARLY_LATE_EN
      s1_neg_reg   <= 1'b0;
`endif
    end else begin
      s1_valid_reg <= gnt_valid;
      s1_mag_reg   <= sel_mag;
      s1_miss_reg  <= sel_miss;
      s1_ch_reg    <= gnt_idx;
`ifdef SC_EARLY_LATE_EN
      s1_neg_reg   <= sel_neg;
`endif
    end
  end

  // ---------------- S2: classification and base points ----------------
  grade_e     cls_next;
  logic [6:0] pts_next;
  logic       s2_valid_reg;
  grade_e     s2_grade_reg;
  logic [2:0] s2_ch_reg;
  logic [6:0] s2_pts_reg;
`ifdef SC_EARLY_LATE_EN
  logic       s2_early_reg;
`endif

  always_comb begin
    if (s1_miss_reg || (s1_mag_reg > MW'(WIN_OK)))
      cls_next = GR_MISS;
    else if (s1_mag_reg <= MW'(WIN_PERFECT))
      cls_next = GR_PERFECT;
    else if (s1_mag_reg <= MW'(WIN_GOOD))
      cls_next = GR_GOOD;
    else
      cls_next = GR_OK;
    pts_next = grade_points(cls_next);
`ifdef SC_EARLY_LATE_EN
    if (s1_neg_reg && (cls_next == GR_GOOD || cls_next == GR_OK))
      pts_next = pts_next - EARLY_PENALTY;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_grade_reg <= GR_MISS;
      s2_ch_reg    <= 3'd0;
      s2_pts_reg   <= '0;
`ifdef SC_EARLY_LATE_EN
      s2_early_reg <= 1'b0;
`endif
    end else begin
      s2_valid_reg <= s1_valid_reg;
      s2_grade_reg <= cls_next;
      s2_ch_reg    <= s1_ch_reg;
      s2_pts_reg   <= pts_next;
`ifdef SC_EARLY_LATE_EN
      s2_early_reg <= s1_neg_reg;
`endif
    end
  end

  // ---------------- score / streak / multiplier ----------------
  logic [SW-1:0] score_reg;
  logic [15:0]   streak_reg;
  logic [15:0]   step_reg;
  logic [2:0]    mult_reg;
  logic          gv_reg;
  logic [1:0]    grade_reg;
  logic [2:0]    gch_reg;
  logic          ovf_reg;
  logic [9:0]    add_pts;
  logic [SW:0]   sum;
`ifdef SC_EARLY_LATE_EN
  logic          early_reg;
`endif

  // Scaled by the multiplier in force before this event updates it.
  assign add_pts = 10'(s2_pts_reg) * 10'(mult_reg);
  assign sum     = {1'b0, score_reg} + (SW+1)'(add_pts);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score_reg  <= '0;
      streak_reg <= 16'd0;
      step_reg   <= 16'd0;
      mult_reg   <= 3'd1;
      gv_reg     <= 1'b0;
      grade_reg  <= 2'd0;
      gch_reg    <= 3'd0;
      ovf_reg    <= 1'b0;
`ifdef SC_EARLY_LATE_EN
      early_reg  <= 1'b0;
`endif
    end else begin
      gv_reg <= s2_valid_reg;
      if (|drop) ovf_reg <= 1'b1;
      if (s2_valid_reg) begin
        grade_reg <= s2_grade_reg;
        gch_reg   <= s2_ch_reg;
`ifdef SC_EARLY_LATE_EN
        early_reg <= s2_early_reg;
`endif
        score_reg <= sum[SW] ? '1 : sum[SW-1:0];
        if (s2_grade_reg == GR_MISS) begin
          streak_reg <= 16'd0;
          step_reg   <= 16'd0;
          mult_reg   <= 3'd1;
        end else begin
          if (streak_reg != 16'hFFFF) streak_reg <= streak_reg + 16'd1;
          if (step_reg == 16'(STREAK_STEP - 1)) begin
            step_reg <= 16'd0;
            if (mult_reg < 3'(MAX_MULT)) mult_reg <= mult_reg + 3'd1;
          end else begin
            step_reg <= step_reg + 16'd1;
          end
        end
      end
    end
  end

  assign bus.score       = score_reg;
  assign bus.streak      = streak_reg;
  assign bus.mult        = mult_reg;
  assign bus.grade_valid = gv_reg;
  assign bus.grade       = grade_reg;
  assign bus.grade_ch    = gch_reg;
  assign bus.overflow    = ovf_reg;
`ifdef SC_EARLY_LATE_EN
  assign bus.early       = early_reg;
`else
  assign bus.early       = 1'b0;
`endif

endmodule

// File: tb/tb_sc_score_engine.sv
// tb_sc_score_engine: directed self-checking bench for sc_score_engine.
// Expected grades are queued when an event is driven; a negedge monitor pops
// them on each grade_valid and checks grade, fret, early, latency and a
// reference score/streak/multiplier model.
module tb_sc_score_engine;
  import sc_pkg::*;

  localparam int N_CH = 5;
  localparam int TW   = 16;
  localparam int SW   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sc_score_engine_if #(.N_CH(N_CH), .TW(TW), .SW(SW)) bus ();

  sc_score_engine #(
    .N_CH(N_CH), .TW(TW), .SW(SW), .WIN_PERFECT(8), .WIN_GOOD(24),
    .WIN_OK(48), .STREAK_STEP(10), .MAX_MULT(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int ch;
    int grade;
    bit early;
    int cyc;
  } exp_t;

  exp_t   sb[$];
  int     n_cmp   = 0;
  int     n_bad   = 0;
  int     cyc     = 0;
  int     gv_seen = 0;
  longint m_score = 0;
  int     m_streak = 0;
  int     m_step   = 0;
  int     m_mult   = 1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor + reference model.
  always @(negedge clk) begin
    exp_t e;
    int   pts;
    if (rst) begin
      m_score = 0; m_streak = 0; m_step = 0; m_mult = 1;
    end else if (bus.grade_valid) begin
      gv_seen++;
      n_cmp++;
      assert (sb.size() > 0) else begin
        n_bad++;
        $error("FAIL spurious_grade_valid: observed grade_ch %0d expected no event", bus.grade_ch);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.grade)
          3: pts = 100;
          2: pts = 50;
          1: pts = 20;
          default: pts = 0;
        endcase
`ifdef SC_EARLY_LATE_EN
        if (e.early && (e.grade == 1 || e.grade == 2)) pts = pts - 10;
`endif
        m_score = m_score + pts * m_mult;
        if (m_score > 64'hFFFF_FFFF) m_score = 64'hFFFF_FFFF;
        if (e.grade == 0) begin
          m_streak = 0; m_step = 0; m_mult = 1;
        end else begin
          m_streak++;
          m_step++;
          if (m_step == 10) begin
            m_step = 0;
            if (m_mult < 4) m_mult++;
          end
        end
        $display("grade ch=%0d grade=%0d early=%0d score=%0d streak=%0d mult=%0d cyc=%0d",
                 bus.grade_ch, bus.grade, bus.early, bus.score, bus.streak, bus.mult, cyc);
        check("grade", bus.grade, e.grade);
        check("grade_ch", bus.grade_ch, e.ch);
        check("early", bus.early, e.early);
        check("score", bus.score, m_score);
        check("streak", bus.streak, m_streak);
        check("mult", bus.mult, m_mult);
        if (e.cyc >= 0) check("latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_dt(input int ch, input int dt);
    bus.hit_time[ch*TW +: TW] = bus.song_time - 16'(dt);
  endtask

  task automatic pulse(input logic [4:0] hv, input logic [4:0] ms);
    bus.hit_valid = hv;
    bus.miss      = ms;
    tick(1);
    bus.hit_valid = '0;
    bus.miss      = '0;
  endtask

  task automatic push(input int ch, input int g, input bit early, input int c);
    exp_t e;
    e.ch = ch; e.grade = g; e.early = early; e.cyc = c;
    sb.push_back(e);
  endtask

  function automatic int exp_grade(input int dt);
    int a;
    a = (dt < 0) ? -dt : dt;
    if (a > 48) return 0;
    if (a <= 8) return 3;
    if (a <= 24) return 2;
    return 1;
  endfunction

  function automatic bit exp_early(input int dt);
`ifdef SC_EARLY_LATE_EN
    return dt < 0;
`else
    return (dt < 0) && 1'b0;
`endif
  endfunction

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (sb.size() > 0 && k < budget) begin
      tick(1);
      k++;
    end
    check("drain_empty", sb.size(), 0);
    tick(3);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_score"}, bus.score, 0);
    check({tag, "_streak"}, bus.streak, 0);
    check({tag, "_mult"}, bus.mult, 1);
    check({tag, "_grade_valid"}, bus.grade_valid, 0);
    check({tag, "_grade"}, bus.grade, 0);
    check({tag, "_grade_ch"}, bus.grade_ch, 0);
    check({tag, "_early"}, bus.early, 0);
    check({tag, "_overflow"}, bus.overflow, 0);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    sb.delete();
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    int dts[8];
    dts = '{8, 9, 24, 25, 48, -48, -8, -49};
    bus.pause     = 1'b0;
    bus.song_time = '0;
    bus.hit_valid = '0;
    bus.hit_time  = '0;
    bus.miss      = '0;
    tick(3);
    check_reset_vals("reset");
    rst = 1'b0;
    tick(2);

    // Single PERFECT hit, 3-cycle latency.
    bus.song_time = 16'd1000;
    set_dt(0, 3);
    push(0, 3, 0, cyc + 4);
    pulse(5'b00001, 5'b00000);
    drain(20);
    check("single_score", bus.score, 100);

    // Ten PERFECTs then a GOOD at multiplier 2.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_dt(i % 5, i % 3);
      push(i % 5, 3, 0, cyc + 4);
      pulse(5'(1 << (i % 5)), 5'b00000);
    end
    set_dt(0, 20);
    push(0, 2, 0, cyc + 4);
    pulse(5'b00001, 5'b00000);
    drain(30);
    check("streak_score", bus.score, 1100);
    check("streak_mult", bus.mult, 2);

    // All frets at once: back-to-back grades 0..4.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_dt(i, 0);
      push(i, 3, 0, cyc + 4 + i);
    end
    pulse(5'b11111, 5'b00000);
    drain(30);
    check("burst_overflow", bus.overflow, 0);

    // Song-time wrap, then a MISS by window.
    bus.song_time = 16'd3;
    bus.hit_time[1*TW +: TW] = 16'd65530;
    push(1, 2, 0, cyc + 4);
    pulse(5'b00010, 5'b00000);
    bus.hit_time[1*TW +: TW] = 16'd65490;
    push(1, 0, 0, cyc + 4);
    pulse(5'b00010, 5'b00000);
    drain(20);
    check("wrap_miss_streak", bus.streak, 0);
    check("wrap_miss_mult", bus.mult, 1);

    // Window boundaries, both signs, plus an explicit miss.
    bus.song_time = 16'd500;
    for (int i = 0; i < 8; i++) begin
      set_dt(0, dts[i]);
      push(0, exp_grade(dts[i]), exp_early(dts[i]), cyc + 4);
      pulse(5'b00001, 5'b00000);
    end
    push(3, 0, 0, cyc + 4);
    pulse(5'b00000, 5'b01000);
    drain(30);

    // Pause holds two pending frets.
    do_reset();
    bus.pause = 1'b1;
    set_dt(1, 0);
    set_dt(3, 10);
    pulse(5'b01010, 5'b00000);
    gv_seen = 0;
    tick(6);
    check("pause_no_grade", gv_seen, 0);
    push(1, 3, 0, cyc + 3);
    push(3, 2, 0, cyc + 4);
    bus.pause = 1'b0;
    drain(20);

    // Second event on a pending, paused fret is dropped.
    do_reset();
    bus.pause = 1'b1;
    set_dt(2, 0);
    pulse(5'b00100, 5'b00000);
    set_dt(2, 40);
    pulse(5'b00100, 5'b00000);
    check("pending_overflow", bus.overflow, 1);
    push(2, 3, 0, cyc + 3);
    gv_seen = 0;
    bus.pause = 1'b0;
    drain(20);
    check("pending_one_grade", gv_seen, 1);

    // Hit and miss on one fret in the same cycle: hit kept, overflow set.
    do_reset();
    set_dt(4, 3);
    push(4, 3, 0, cyc + 4);
    pulse(5'b10000, 5'b10000);
    drain(20);
    check("hit_miss_overflow", bus.overflow, 1);

    // Event in the grant cycle refills without loss.
    do_reset();
    set_dt(0, 0);
    push(0, 3, 0, cyc + 4);
    pulse(5'b00001, 5'b00000);
    set_dt(0, 30);
    push(0, 1, exp_early(30), cyc + 4);
    pulse(5'b00001, 5'b00000);
    drain(20);
    check("refill_overflow", bus.overflow, 0);

    // Reset with events in flight.
    for (int i = 0; i < 5; i++) set_dt(i, 0);
    pulse(5'b11111, 5'b00000);
    tick(2);
    rst = 1'b1;
    sb.delete();
    #1;
    check_reset_vals("midreset");
    tick(1);
    rst = 1'b0;
    gv_seen = 0;
    tick(12);
    check("midreset_no_grade", gv_seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
